fft8_input_loader: RTL
======================

Name: fft8_input_loader

Overview:
- Upstream stage of the 8-point FFT datapath. Accepts complex samples serially over a valid/ready stream.
- Writes each sample into slot bitrev3(index), so the butterfly network receives a parallel frame already in bit-reversed order.
- Ping-pong banks let bank A fill while bank B is presented to the combinational butterfly stages. This sustains one sample per clock.

Parameters:
- N, 4, width exponent; sample component width W = 2**N bits, two's complement (matches the butterfly datapath).
- POINTS, 8, frame length; fixed at 8, index width 3.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous frame abort; discards partial and stored frames
- in_valid  in  1  input sample valid
- in_ready  out  1  loader can accept a sample this cycle
- in_r  in  W  sample real part
- in_i  in  W  sample imaginary part
- out_valid  out  1  full bit-reversed frame presented
- out_ready  in  1  downstream consumes frame this cycle
- out_r  out  8*W  frame real parts; slot s occupies bits [s*W +: W]
- out_i  out  8*W  frame imaginary parts; same packing as out_r

Behaviour:
- State registers:
  - wr_bank (1b), wr_cnt (3b)
  - rd_bank (1b)
  - full[1:0]
  - two banks of 8 x (W real, W imag) registers
- Reset (rst high, asynchronous):
  - wr_cnt=0, wr_bank=0, rd_bank=0, full=2'b00.
  - in_ready=1, out_valid=0.
  - Bank contents are cleared to 0, so out_r/out_i read 0.
  - Reset asserted mid-frame discards everything; no partial frame is ever presented.
- in_ready = !full[wr_bank] && !flush (combinational from registers and flush).
- Write accept = in_valid && in_ready:
  - bank[wr_bank].slot[bitrev3(wr_cnt)] <= {in_r, in_i}; wr_cnt <= wr_cnt+1 (wraps 7->0).
  - When wr_cnt==7 on accept: full[wr_bank] <= 1 and wr_bank toggles.
- out_valid = full[rd_bank]. out_r/out_i are driven directly from bank[rd_bank], with no extra register stage.
- Latency: out_valid rises immediately after the clock edge that accepts the 8th sample, i.e. 1 cycle after that sample is presented, when the read bank is idle.
- Read accept = out_valid && out_ready: full[rd_bank] <= 0 and rd_bank toggles.
- While out_valid && !out_ready, out_r/out_i stay stable. Writes never target rd_bank while it is full.
- Simultaneous events:
  - A write completion on one bank and a read accept on the other in the same cycle both take effect.
  - Set and clear on the same bank cannot coincide: set requires !full and clear requires full.
- Both banks full: in_ready=0 until a read accept frees a bank. The freed bank becomes writable the next cycle.
- flush (synchronous, highest priority after rst):
  - Effect: wr_cnt=0, full=2'b00, wr_bank=rd_bank=0.
  - Data registers are not cleared.
  - Any write or read accept in the flush cycle is ignored; in_ready=0 during flush.
- in_valid with in_ready=0: the sample is not taken, and the upstream holds it.
- No arithmetic is performed. Data passes bit-exact; no scaling or sign changes.

Decomposition:
- Shared package fft8_pkg:
  - constants POINTS=8 and IDX_W=3
  - function bitrev3(idx) returning {idx[0],idx[1],idx[2]}
  - a complex-sample struct {re, im} of width W
- One natural sub-module: fft8_frame_bank, an 8-slot complex register bank.
  - Inputs: clk, rst, we, waddr[2:0], wdata.
  - Output: flattened out_r/out_i.
  - Instantiated twice. The top level holds counters, full flags, bank select and output muxing.

Test Plan:
- Single frame: after reset, push samples k=0..7 with in_r=k+1 and in_i=-(k+1), out_ready=0.
  - Expect out_valid=1 one cycle after the 8th accept.
  - Expect out_r slots 0..7 = 1,5,3,7,2,6,4,8.
  - Expect out_i to be the negatives of those values.
- Back-to-back streaming: in_valid held high for 24 samples, out_ready=1.
  - Expect in_ready never to drop.
  - Expect three frames, each with one out_valid pulse, spaced 8 cycles apart, with correct bit-reversed contents.
- Backpressure: out_ready=0 while pushing 20 samples.
  - Expect in_ready=0 after the 16th accept, and both frames held stable.
  - Raise out_ready for 1 cycle: frame 1 is released, frame 2 is presented next cycle, and in_ready returns to 1.
- Mid-frame reset: assert rst after 5 samples.
  - Expect out_valid=0, in_ready=1 and out_r=0 immediately (asynchronously).
  - A fresh 8-sample frame then produces the correct output with no leftover data.
- Flush: flush for 1 cycle with one full bank plus 3 partial samples, with in_valid=1 during the flush.
  - Expect in_ready=0 and no accept in that cycle.
  - Afterwards expect out_valid=0, and the next 8 samples form frame 0 in bank 0.
- Boundary values: samples 16'h7FFF / 16'h8000 alternating.
  - Expect bit-exact pass-through in bit-reversed slots, with no sign corruption.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT front end: frame geometry,
// bit-reversal helper and the complex sample payload.
package fft8_pkg;

  localparam int unsigned POINTS = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned N_DEF  = 4;
  localparam int unsigned W_DEF  = 1 << N_DEF;

  // Complex sample at the default datapath width.
  typedef struct packed {
    logic [W_DEF-1:0] re;
    logic [W_DEF-1:0] im;
  } sample_t;

  // Reverse the three index bits: slot order expected by the butterflies.
  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/fft8_frame_bank.sv
// 8-slot complex register bank holding one FFT frame.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears all slots)
//   we, waddr     write strobe and slot address
//   wdata         {re, im} sample to write
//   out_r, out_i  all slots flattened; slot s at [s*W +: W]
module fft8_frame_bank
  import fft8_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [2*W-1:0]        wdata,
  output logic [POINTS*W-1:0]   out_r,
  output logic [POINTS*W-1:0]   out_i
);

  logic [W-1:0] re_q [POINTS];
  logic [W-1:0] im_q [POINTS];

  // Slot storage; only the addressed slot updates on a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(POINTS); s++) begin
        re_q[s] <= '0;
        im_q[s] <= '0;
      end
    end else if (we) begin
      re_q[waddr] <= wdata[2*W-1:W];
      im_q[waddr] <= wdata[W-1:0];
    end
  end

  // Flatten slots onto the parallel frame buses.
  for (genvar s = 0; s < int'(POINTS); s++) begin : g_flat
    assign out_r[s*W +: W] = re_q[s];
    assign out_i[s*W +: W] = im_q[s];
  end

endmodule

// File: rtl/fft8_input_loader.sv
// Serial-to-parallel loader for the 8-point FFT. Samples arrive one per
// clock and land in slot bitrev3(index) of the write bank; a completed
// bank is presented as a parallel frame while the other bank fills.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous abort of partial and stored frames
//   in_valid/in_ready   sample stream handshake; in_r/in_i sample data
//   out_valid/out_ready frame handshake; out_r/out_i frame, slot s at [s*W +: W]
module fft8_input_loader
  import fft8_pkg::*;
#(
  parameter  int unsigned N = N_DEF,
  localparam int unsigned W = 1 << N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_r,
  input  logic [W-1:0]        in_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [POINTS*W-1:0] out_r,
  output logic [POINTS*W-1:0] out_i
);

  logic [IDX_W-1:0] wr_cnt, wr_cnt_d;
  logic             wr_bank, wr_bank_d;
  logic             rd_bank, rd_bank_d;
  logic [1:0]       full, full_d;

  logic             wr_acc;
  logic             rd_acc;
  logic [IDX_W-1:0] waddr;
  logic [2*W-1:0]   wdata;
  logic [POINTS*W-1:0] b0_r, b0_i, b1_r, b1_i;

  // Flush blocks both handshakes in its cycle.
  assign in_ready  = !full[wr_bank] && !flush;
  assign out_valid = full[rd_bank];
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready && !flush;

  assign waddr = bitrev3(wr_cnt);
  assign wdata = {in_r, in_i};

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      wr_cnt  <= wr_cnt_d;
      wr_bank <= wr_bank_d;
      rd_bank <= rd_bank_d;
      full    <= full_d;
    end
  end

  // Next-state: write completion and read accept touch different banks,
  // so both may apply in the same cycle.
  always_comb begin
    wr_cnt_d  = wr_cnt;
    wr_bank_d = wr_bank;
    rd_bank_d = rd_bank;
    full_d    = full;
    if (flush) begin
      wr_cnt_d  = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      full_d    = 2'b00;
    end else begin
      if (wr_acc) begin
        wr_cnt_d = wr_cnt + IDX_W'(1);
        if (wr_cnt == IDX_W'(POINTS - 1)) begin
          full_d[wr_bank] = 1'b1;
          wr_bank_d       = ~wr_bank;
        end
      end
      if (rd_acc) begin
        full_d[rd_bank] = 1'b0;
        rd_bank_d       = ~rd_bank;
      end
    end
  end

  fft8_frame_bank #(.W(W)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !wr_bank),
    .waddr (waddr),
    .wdata (wdata),
    .out_r (b0_r),
    .out_i (b0_i)
  );

  fft8_frame_bank #(.W(W)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && wr_bank),
    .waddr (waddr),
    .wdata (wdata),
    .out_r (b1_r),
    .out_i (b1_i)
  );

  // Present the read bank directly, no output register stage.
  assign out_r = rd_bank ? b1_r : b0_r;
  assign out_i = rd_bank ? b1_i : b0_i;

endmodule
